// File: rtl/volumen_uart_tx_if.sv
// Request/data/status bundle between the volume summer side and the UART frame transmitter.
// The master drives the request and payload; the slave (transmitter) drives the line and status.
interface volumen_uart_tx_if;
  logic        ce;
  logic        send;
  logic [13:0] volumen;
  logic [1:0]  state_machine;
  logic        tx;
  logic        busy;
  logic        done;

  modport master (
    output ce, send, volumen, state_machine,
    input  tx, busy, done
  );

  modport slave (
    input  ce, send, volumen, state_machine,
    output tx, busy, done
  );
endinterface

// File: rtl/volumen_uart_tx.sv
// Sends the 14-bit volume and 2-bit state code as a 4-byte 8N1 UART frame:
// header, {state, vol[13:8]}, vol[7:0], XOR checksum of the first three bytes.
module volumen_uart_tx #(
  parameter int         CLKS_PER_BIT = 5208,
  parameter logic [7:0] HEADER       = 8'hA5
) (
  input  logic           clk,
  input  logic           rst_n,
  volumen_uart_tx_if.slave bus
);

  localparam int                  TIMER_W    = $clog2(CLKS_PER_BIT);
  localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state, state_next;
  logic [TIMER_W-1:0] timer, timer_next;
  logic [2:0]         bit_idx, bit_idx_next;
  logic [1:0]         byte_idx, byte_idx_next;
  logic [13:0]        vol_q, vol_next;
  logic [1:0]         sm_q, sm_next;
  logic               tx_q, tx_next;
  logic               busy_q, busy_next;
  logic               done_q, done_next;
  logic [7:0]         byte1, byte2, cur_byte;
  logic               bit_end;

  assign byte1   = {sm_q, vol_q[13:8]};
  assign byte2   = vol_q[7:0];
  assign bit_end = (timer == TIMER_LAST);

  always_comb begin
    unique case (byte_idx)
      2'd0:    cur_byte = HEADER;
      2'd1:    cur_byte = byte1;
      2'd2:    cur_byte = byte2;
      default: cur_byte = HEADER ^ byte1 ^ byte2;
    endcase
  end

  // Clock enable gates every register, so a frozen enable stretches the current bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      timer    <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      vol_q    <= '0;
      sm_q     <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (bus.ce) begin
      state    <= state_next;
      timer    <= timer_next;
      bit_idx  <= bit_idx_next;
      byte_idx <= byte_idx_next;
      vol_q    <= vol_next;
      sm_q     <= sm_next;
      tx_q     <= tx_next;
      busy_q   <= busy_next;
      done_q   <= done_next;
    end
  end

  always_comb begin
    state_next    = state;
    timer_next    = timer;
    bit_idx_next  = bit_idx;
    byte_idx_next = byte_idx;
    vol_next      = vol_q;
    sm_next       = sm_q;
    tx_next       = tx_q;
    busy_next     = busy_q;
    done_next     = 1'b0;

    unique case (state)
      IDLE: begin
        tx_next   = 1'b1;
        busy_next = 1'b0;
        if (bus.send) begin
          vol_next      = bus.volumen;
          sm_next       = bus.state_machine;
          state_next    = START;
          timer_next    = '0;
          bit_idx_next  = '0;
          byte_idx_next = '0;
          tx_next       = 1'b0;
          busy_next     = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          timer_next   = '0;
          bit_idx_next = '0;
          state_next   = DATA;
          tx_next      = cur_byte[0];
        end else begin
          timer_next = timer + TIMER_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          timer_next = '0;
          if (bit_idx == 3'd7) begin
            state_next = STOP;
            tx_next    = 1'b1;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
            tx_next      = cur_byte[3'(bit_idx + 3'd1)];
          end
        end else begin
          timer_next = timer + TIMER_W'(1);
        end
      end
      default: begin
        if (bit_end) begin
          timer_next = '0;
          if (byte_idx == 2'd3) begin
            state_next = IDLE;
            tx_next    = 1'b1;
            busy_next  = 1'b0;
            done_next  = 1'b1;
          end else begin
            byte_idx_next = byte_idx + 2'd1;
            state_next    = START;
            tx_next       = 1'b0;
          end
        end else begin
          timer_next = timer + TIMER_W'(1);
        end
      end
    endcase
  end

  assign bus.tx   = tx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_volumen_uart_tx.sv
// Directed bench for volumen_uart_tx with 4 clocks per bit: decodes frames from the
// line, checks bit timing, busy/done timing, input capture, reset abort and clock enable.
module tb_volumen_uart_tx;

  localparam int CPB = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  volumen_uart_tx_if bus ();

  volumen_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .HEADER      (8'hA5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic expBit(input logic [31:0] frame, input int i);
    logic [7:0] b;
    int         pos;
    b   = 8'(frame >> (8 * (3 - i / 10)));
    pos = i % 10;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return b[pos - 1];
  endfunction

  // Caller raises send at a negedge; the frame is accepted on the following posedge.
  // Samples each negedge, checks every line sample against the expected bit stream,
  // decodes mid-bit samples, and checks busy/done up to the frame end.
  task automatic applyStimulus(input string tag, input logic [31:0] frame, input int rpb,
                               input bit toggle_ce, input bit hold_send, input int poke_at,
                               input logic [13:0] poke_vol, input logic [1:0] poke_sm,
                               input bit extra_sends);
    logic [7:0] got [4];
    bit         stream_ok;
    bit         busy_ok;
    bit         done_ok;
    int         total;
    total     = 40 * rpb;
    stream_ok = 1'b1;
    busy_ok   = 1'b1;
    done_ok   = 1'b1;
    for (int k = 0; k < 4; k++) got[k] = 8'h00;
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, "_accept_tx"}, 32'(bus.tx), 32'd0);
    checkOutput({tag, "_accept_busy"}, 32'(bus.busy), 32'd1);
    checkOutput({tag, "_accept_done"}, 32'(bus.done), 32'd0);
    for (int c = 0; c <= total; c++) begin
      if (c > 0) @(negedge clk);
      if (c == total) begin
        bus.ce = 1'b1;
        checkOutput({tag, "_end_tx"}, 32'(bus.tx), 32'd1);
        checkOutput({tag, "_end_busy"}, 32'(bus.busy), 32'd0);
        checkOutput({tag, "_end_done"}, 32'(bus.done), 32'd1);
      end else begin
        if (bus.tx !== expBit(frame, c / rpb)) stream_ok = 1'b0;
        if (bus.busy !== 1'b1) busy_ok = 1'b0;
        if (bus.done !== 1'b0) done_ok = 1'b0;
        if ((c % rpb) == rpb / 2 && ((c / rpb) % 10) >= 1 && ((c / rpb) % 10) <= 8)
          got[(c / rpb) / 10][((c / rpb) % 10) - 1] = bus.tx;
        if (c == 0 && !hold_send) bus.send = 1'b0;
        if (extra_sends && (c == 10 || c == 50)) bus.send = 1'b1;
        if (extra_sends && (c == 11 || c == 51)) bus.send = 1'b0;
        if (c == poke_at) begin
          bus.volumen       = poke_vol;
          bus.state_machine = poke_sm;
        end
        if (toggle_ce) bus.ce = (c % 2 == 1);
      end
    end
    checkOutput({tag, "_byte0"}, 32'(got[0]), 32'(frame[31:24]));
    checkOutput({tag, "_byte1"}, 32'(got[1]), 32'(frame[23:16]));
    checkOutput({tag, "_byte2"}, 32'(got[2]), 32'(frame[15:8]));
    checkOutput({tag, "_byte3"}, 32'(got[3]), 32'(frame[7:0]));
    checkOutput({tag, "_bitstream"}, 32'(stream_ok), 32'd1);
    checkOutput({tag, "_busy_held"}, 32'(busy_ok), 32'd1);
    checkOutput({tag, "_no_early_done"}, 32'(done_ok), 32'd1);
  endtask

  initial begin
    bit idle_ok;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.ce   = 1'b1;
    bus.send = 1'b0;
    bus.volumen       = 14'h0000;
    bus.state_machine = 2'b00;

    // Power-on reset state.
    repeat (3) @(negedge clk);
    checkOutput("reset_tx", 32'(bus.tx), 32'd1);
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_done", 32'(bus.done), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Test 1: reset asserted mid-frame aborts it.
    bus.volumen       = 14'h1234;
    bus.state_machine = 2'b01;
    bus.send          = 1'b1;
    @(negedge clk);
    bus.send = 1'b0;
    checkOutput("t1_started_busy", 32'(bus.busy), 32'd1);
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("t1_async_tx", 32'(bus.tx), 32'd1);
    checkOutput("t1_async_busy", 32'(bus.busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("t1_rst_tx", 32'(bus.tx), 32'd1);
      checkOutput("t1_rst_busy", 32'(bus.busy), 32'd0);
      checkOutput("t1_rst_done", 32'(bus.done), 32'd0);
    end
    rst_n   = 1'b1;
    idle_ok = 1'b1;
    for (int i = 0; i < 170; i++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.tx !== 1'b1 || bus.busy !== 1'b0) idle_ok = 1'b0;
    end
    checkOutput("t1_idle_after_abort", 32'(idle_ok), 32'd1);
    bus.send = 1'b1;
    applyStimulus("t1_clean", {8'hA5, 8'h52, 8'h34, 8'hC3}, CPB, 1'b0, 1'b0, -1, 14'h0, 2'b0, 1'b0);
    @(negedge clk);
    checkOutput("t1_done_cleared", 32'(bus.done), 32'd0);

    // Test 2: basic frame 1234 / state 01.
    repeat (3) @(negedge clk);
    bus.send = 1'b1;
    applyStimulus("t2", {8'hA5, 8'h52, 8'h34, 8'hC3}, CPB, 1'b0, 1'b0, -1, 14'h0, 2'b0, 1'b0);
    @(negedge clk);
    checkOutput("t2_done_pulse", 32'(bus.done), 32'd0);
    checkOutput("t2_idle_tx", 32'(bus.tx), 32'd1);

    // Test 3: all-ones payload; volume changed mid-frame must not alter it.
    repeat (3) @(negedge clk);
    bus.volumen       = 14'h3FFF;
    bus.state_machine = 2'b11;
    bus.send          = 1'b1;
    applyStimulus("t3", {8'hA5, 8'hFF, 8'hFF, 8'hA5}, CPB, 1'b0, 1'b0, 20, 14'h0000, 2'b11, 1'b0);

    // Test 4: send held high; second frame uses inputs changed during the first.
    repeat (3) @(negedge clk);
    bus.volumen       = 14'h0ABC;
    bus.state_machine = 2'b10;
    bus.send          = 1'b1;
    applyStimulus("t4_first", {8'hA5, 8'h8A, 8'hBC, 8'h93}, CPB, 1'b0, 1'b1, 100, 14'h0000, 2'b00, 1'b0);
    applyStimulus("t4_second", {8'hA5, 8'h00, 8'h00, 8'hA5}, CPB, 1'b0, 1'b0, -1, 14'h0, 2'b0, 1'b0);

    // Test 5: requests during a frame are dropped.
    repeat (3) @(negedge clk);
    bus.volumen       = 14'h1234;
    bus.state_machine = 2'b01;
    bus.send          = 1'b1;
    applyStimulus("t5", {8'hA5, 8'h52, 8'h34, 8'hC3}, CPB, 1'b0, 1'b0, -1, 14'h0, 2'b0, 1'b1);
    idle_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0) idle_ok = 1'b0;
    end
    checkOutput("t5_single_frame", 32'(idle_ok), 32'd1);

    // Test 6: clock enable toggling every cycle doubles every bit.
    bus.send = 1'b1;
    applyStimulus("t6", {8'hA5, 8'h52, 8'h34, 8'hC3}, 2 * CPB, 1'b1, 1'b0, -1, 14'h0, 2'b0, 1'b0);
    @(negedge clk);
    checkOutput("t6_done_cleared", 32'(bus.done), 32'd0);
    checkOutput("t6_idle_busy", 32'(bus.busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
